uart_cmd_sequencer: RTL and testbench

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_timeout_counter.sv | 33 +++
 rtl/uart_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the UART command sequencer: FSM encoding,
// framing bytes, command codes and error codes.
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CMD       = 4'd1,
    ST_LEN_HI    = 4'd2,
    ST_LEN_LO    = 4'd3,
    ST_DATA      = 4'd4,
    ST_WRITE     = 4'd5,
    ST_RUN       = 4'd6,
    ST_WAIT_DONE = 4'd7
  } seq_state_e;

  localparam logic [7:0] HDR_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_RUN    = 8'h02;
  localparam logic [7:0] CMD_CLRPTR = 8'h03;

  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_BAD_CMD = 4'd1;
  localparam logic [3:0] ERR_GAP     = 4'd2;
  localparam logic [3:0] ERR_RUN     = 4'd3;

  // States in which the inter-byte gap timer is running
  function automatic logic in_frame(input seq_state_e s);
    return (s inside {ST_CMD, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE});
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating timeout counter: counts enabled cycles since the last clear and
// flags expiry once the count has reached the limit.
module seq_timeout_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // Count register; holds at the limit so it never wraps back to zero
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != i_limit)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses A5-framed UART commands: LOAD streams words into memory, RUN pulses
// the accelerator and waits for done, CLRPTR rewinds the write pointer.
module uart_cmd_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int GAP_TIMEOUT = 1_000_000,
  parameter int RUN_TIMEOUT = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_rxValid,
  input  logic [7:0]        io_rxData,
  input  logic              io_start,
  output logic              io_memWrEn,
  output logic [ADDR_W-1:0] io_memWrAddr,
  output logic [31:0]       io_memWrData,
  output logic              io_accelStart,
  input  logic              io_accelDone,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_error,
  output logic [7:0]        io_status
);

  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1) + 1;
  localparam int RUN_W = $clog2(RUN_TIMEOUT + 1) + 1;
  localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(RUN_TIMEOUT);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  seq_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [1:0]        r_idx, w_idx_nxt;
  logic [15:0]       r_len, w_len_nxt;
  logic [23:0]       r_word, w_word_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [31:0]       r_wr_data, w_wr_data_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [3:0]        r_err_code, w_err_code_nxt;
  logic              r_start_prev, r_wr_en, r_accel_start, r_busy;
  logic              w_start_edge, w_gap_exp, w_run_exp;

  assign w_start_edge = io_start & ~r_start_prev;

  seq_timeout_counter #(.W(GAP_W)) u_gap_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (io_rxValid | ~in_frame(r_state)),
    .i_enable  (1'b1),
    .i_limit   (GAP_LIMIT),
    .o_expired (w_gap_exp)
  );

  seq_timeout_counter #(.W(RUN_W)) u_run_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (r_state != ST_WAIT_DONE),
    .i_enable  (1'b1),
    .i_limit   (RUN_LIMIT),
    .o_expired (w_run_exp)
  );

  // Next-state and datapath decisions; an arriving byte always beats a gap timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len;
    w_word_nxt     = r_word;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_err_code_nxt = r_err_code;
    case (r_state)
      ST_IDLE: begin
        if (io_rxValid && (io_rxData == HDR_BYTE)) begin
          w_state_nxt    = ST_CMD;
          w_error_nxt    = 1'b0;
          w_err_code_nxt = ERR_NONE;
        end else if (w_start_edge) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (io_rxValid) begin
          case (io_rxData)
            CMD_LOAD: begin
              w_state_nxt = ST_LEN_HI;
              w_done_nxt  = 1'b0;
            end
            CMD_RUN:    w_state_nxt = ST_RUN;
            CMD_CLRPTR: begin
              w_ptr_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end
            default: begin
              w_error_nxt    = 1'b1;
              w_err_code_nxt = ERR_BAD_CMD;
              w_state_nxt    = ST_IDLE;
            end
          endcase
        end else if (w_gap_exp) begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_GAP;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_CMD;
        end
      end
      ST_LEN_HI: begin
        if (io_rxValid) begin
          w_len_nxt   = {io_rxData, 8'h00};
          w_state_nxt = ST_LEN_LO;
        end else if (w_gap_exp) begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_GAP;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (io_rxValid) begin
          w_len_nxt   = {r_len[15:8], io_rxData};
          w_idx_nxt   = 2'd0;
          w_state_nxt = ({r_len[15:8], io_rxData} == 16'd0) ? ST_IDLE : ST_DATA;
        end else if (w_gap_exp) begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_GAP;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (io_rxValid) begin
          if (r_idx == 2'd3) begin
            w_wr_data_nxt = {io_rxData, r_word};
            w_wr_addr_nxt = r_ptr;
            w_idx_nxt     = 2'd0;
            w_state_nxt   = ST_WRITE;
          end else begin
            // Bytes shift in from the top so the first one ends up in [7:0]
            w_word_nxt = {io_rxData, r_word[23:8]};
            w_idx_nxt  = r_idx + 2'd1;
          end
        end else if (w_gap_exp) begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_GAP;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_WRITE: begin
        w_ptr_nxt   = r_ptr + PTR_ONE;
        w_len_nxt   = r_len - 16'd1;
        w_state_nxt = (r_len == 16'd1) ? ST_IDLE : ST_DATA;
      end
      ST_RUN: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (io_accelDone) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_run_exp) begin
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_RUN;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; strobes are decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_idx         <= 2'd0;
      r_len         <= 16'd0;
      r_word        <= 24'd0;
      r_wr_addr     <= '0;
      r_wr_data     <= 32'd0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_start_prev  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_accel_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_idx         <= w_idx_nxt;
      r_len         <= w_len_nxt;
      r_word        <= w_word_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_err_code    <= w_err_code_nxt;
      r_start_prev  <= io_start;
      r_wr_en       <= (w_state_nxt == ST_WRITE);
      r_accel_start <= (w_state_nxt == ST_RUN);
      r_busy        <= (w_state_nxt != ST_IDLE);
    end
  end

  assign io_memWrEn    = r_wr_en;
  assign io_memWrAddr  = r_wr_addr;
  assign io_memWrData  = r_wr_data;
  assign io_accelStart = r_accel_start;
  assign io_busy       = r_busy;
  assign io_done       = r_done;
  assign io_error      = r_error;
  assign io_status     = {r_state, r_err_code};

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench: directed frames plus a randomized command mix, compared
// against a transaction-level model of pointer, sticky flags and writes.
module tb_uart_cmd_sequencer;

  localparam int ADDR_W = 2;
  localparam int GAP_T  = 40;
  localparam int RUN_T  = 300;

  logic              clock = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              start;
  logic              accel_done;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              accel_start;
  logic              busy, done, error;
  logic [7:0]        status;

  uart_cmd_sequencer #(.ADDR_W(ADDR_W), .GAP_TIMEOUT(GAP_T), .RUN_TIMEOUT(RUN_T)) dut (
    .clock(clock), .reset(reset), .io_rxValid(rx_valid), .io_rxData(rx_data),
    .io_start(start), .io_memWrEn(mem_wr_en), .io_memWrAddr(mem_wr_addr),
    .io_memWrData(mem_wr_data), .io_accelStart(accel_start), .io_accelDone(accel_done),
    .io_busy(busy), .io_done(done), .io_error(error), .io_status(status)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_start_got = 0;
  int  n_start_exp = 0;
  int  m_ptr = 0;
  bit  m_done = 1'b0;
  bit  m_err = 1'b0;
  int  m_code = 0;

  always @(negedge clock) begin
    if (mem_wr_en === 1'b1) got_q.push_back({mem_wr_addr, mem_wr_data});
    if (accel_start === 1'b1) n_start_got++;
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clock);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clock);
    while (busy === 1'b1 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    chk_val({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_model(input string tag);
    @(negedge clock);
    chk_val({tag, " nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk_val({tag, " wr_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
        chk_val({tag, " wr_data"}, got_q[i].data, exp_q[i].data);
      end
    end
    got_q.delete();
    exp_q.delete();
    chk_val({tag, " starts"}, 32'(n_start_got), 32'(n_start_exp));
    chk_val({tag, " done"}, 32'(done), 32'(m_done));
    chk_val({tag, " error"}, 32'(error), 32'(m_err));
    chk_val({tag, " status"}, 32'(status), 32'(m_code & 15));
  endtask

  task automatic model_header();
    m_err  = 1'b0;
    m_code = 0;
  endtask

  task automatic do_load(input logic [31:0] words[$]);
    int n = words.size();
    send_byte(8'hA5);
    model_header();
    send_byte(8'h01);
    m_done = 1'b0;
    send_byte(8'(n / 256));
    send_byte(8'(n % 256));
    foreach (words[w]) begin
      for (int b = 0; b < 4; b++) send_byte(8'((words[w] >> (8 * b)) & 32'hFF));
      exp_q.push_back({ADDR_W'(m_ptr), words[w]});
      m_ptr = (m_ptr + 1) % (1 << ADDR_W);
    end
  endtask

  task automatic do_clrptr();
    send_byte(8'hA5);
    send_byte(8'h03);
    model_header();
    m_ptr = 0;
  endtask

  task automatic do_bad(input logic [7:0] cmd);
    send_byte(8'hA5);
    send_byte(cmd);
    m_err  = 1'b1;
    m_code = 1;
  endtask

  // delay < 0 means the accelerator never answers
  task automatic do_run(input bit by_button, input int delay);
    if (by_button) begin
      @(posedge clock); #1;
      start = 1'b1;
      repeat (3) @(posedge clock);
      #1 start = 1'b0;
    end else begin
      send_byte(8'hA5);
      model_header();
      send_byte(8'h02);
    end
    n_start_exp++;
    m_done = 1'b0;
    @(negedge clock);
    chk_val("run busy", 32'(busy), 32'd1);
    chk_val("run done low", 32'(done), 32'd0);
    if (delay >= 0) begin
      repeat (delay) @(posedge clock);
      #1 accel_done = 1'b1;
      @(posedge clock); #1;
      accel_done = 1'b0;
      m_done = 1'b1;
    end else begin
      repeat (RUN_T + 20) @(posedge clock);
      m_err  = 1'b1;
      m_code = 3;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words[$];
    logic [7:0]  b;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0; accel_done = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_val("rst wr_en", 32'(mem_wr_en), 32'd0);
    chk_val("rst wr_data", mem_wr_data, 32'd0);
    chk_val("rst start", 32'(accel_start), 32'd0);
    chk_val("rst busy", 32'(busy), 32'd0);
    chk_val("rst status", 32'(status), 32'd0);
    reset = 1'b0;

    words = '{32'h44332211, 32'h88776655};
    do_load(words);
    wait_idle("load2");
    check_model("load2");

    do_run(1'b0, 100);
    wait_idle("run");
    check_model("run");

    do_bad(8'h07);
    wait_idle("badcmd");
    check_model("badcmd");

    // Gap timeout inside the first data word
    send_byte(8'hA5); model_header();
    send_byte(8'h01); m_done = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    repeat (GAP_T - 8) @(posedge clock);
    @(negedge clock);
    chk_val("gap still busy", 32'(busy), 32'd1);
    repeat (20) @(posedge clock);
    m_err = 1'b1; m_code = 2;
    wait_idle("gap");
    check_model("gap");

    do_clrptr();
    words = '{};
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    do_load(words);
    wait_idle("wrap");
    check_model("wrap");
    do_clrptr();
    words = '{$urandom};
    do_load(words);
    wait_idle("clrptr");
    check_model("clrptr");

    do_run(1'b0, -1);
    wait_idle("runtmo");
    check_model("runtmo");

    // Reset in the middle of a data word
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_ptr = 0; m_done = 1'b0; m_err = 1'b0; m_code = 0;
    check_model("reset");
    words = '{32'hCAFE0123};
    do_load(words);
    wait_idle("post reset");
    check_model("post reset");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 6))
        0: begin
          words = '{};
          for (int i = 0; i < int'($urandom_range(0, 5)); i++) words.push_back($urandom);
          do_load(words);
        end
        1: do_clrptr();
        2: do_run(1'b0, int'($urandom_range(5, 150)));
        3: do_run(1'b1, int'($urandom_range(5, 150)));
        4: do_bad(8'($urandom_range(4, 255)));
        5: begin
          for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
          end
        end
        default: do_run(1'b0, -1);
      endcase
      wait_idle("rand");
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
